fb_mode_arbiter: RTL and testbench

- Parametrised frame-buffer front end; replaces the fixed two-mode write mux and the hard-wired read address generator.
- Selects one of N_SRC pixel write sources (e.g. raw camera, nn_rgb output) into the frame buffer write port. Source switches happen only on frame boundaries, so frames never tear.
- Generates the VGA read address and overlays a centroid crosshair on read data.
- Sits between the capture/NN blocks, frame_buffer and the VGA RGB outputs.

---
 rtl/fb_mode_pkg.sv | 21 ++
 rtl/fb_read_overlay.sv | 109 ++++++++++
 rtl/fb_mode_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fb_mode_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_mode_pkg.sv
// Shared types and elaboration-time helpers for the frame-buffer mode arbiter.
package fb_mode_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PENDING = 2'd2,
        S_SWITCH  = 2'd3
    } state_t;

    // Number of pixels in one frame; also the first out-of-range buffer address.
    function automatic int unsigned fb_depth(input int unsigned h_res, input int unsigned v_res);
        return h_res * v_res;
    endfunction

    // Width of a source index; at least one bit.
    function automatic int unsigned mode_w(input int unsigned n_src);
        return (n_src < 2) ? 1 : $clog2(n_src);
    endfunction

endpackage

// File: rtl/fb_read_overlay.sv
// VGA read-address generator with a centroid crosshair drawn over read data.
module fb_read_overlay
    import fb_mode_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 17,
    parameter int unsigned       DATA_W     = 24,
    parameter int unsigned       H_RES      = 320,
    parameter int unsigned       V_RES      = 240,
    parameter int unsigned       MARK_HALF  = 4,
    parameter logic [DATA_W-1:0] MARK_COLOR = 24'hFF0000
) (
    input  logic              clk_25_vga,
    input  logic              btn_RESET,
    input  logic              fs,
    input  logic              active_area,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              overlay_en,
    input  logic [15:0]       x_pos,
    input  logic [15:0]       y_pos,
    output logic [ADDR_W-1:0] buf_rdaddr,
    output logic [DATA_W-1:0] pix_out
);

    localparam int unsigned       DEPTH     = fb_depth(H_RES, V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [15:0]       LAST_X    = 16'(H_RES - 1);
    localparam logic [15:0]       H_LIM     = 16'(H_RES);
    localparam logic [15:0]       V_LIM     = 16'(V_RES);
    localparam logic [16:0]       ARM       = 17'(MARK_HALF);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [15:0]       xd_q, xd_d, yd_q, yd_d;
    logic [15:0]       xl_q, xl_d, yl_q, yl_d;
    logic [DATA_W-1:0] pix_q, pix_d;

    logic signed [16:0] dx, dy;
    logic [16:0]        adx, ady;
    logic               hit, mark_on_screen;

    // Next-state for scan counters, position latch and the overlay stage.
    always_comb begin
        addr_d = addr_q;
        x_d    = x_q;
        y_d    = y_q;
        xl_d   = xl_q;
        yl_d   = yl_q;
        if (fs) begin
            addr_d = '0;
            x_d    = '0;
            y_d    = '0;
            xl_d   = x_pos;
            yl_d   = y_pos;
        end else if (active_area) begin
            if (addr_q == LAST_ADDR) begin
                addr_d = '0;
                x_d    = '0;
                y_d    = '0;
            end else begin
                addr_d = addr_q + 1'b1;
                if (x_q == LAST_X) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end

        // x/y delayed one cycle so they line up with rd_data for the same address.
        xd_d = x_q;
        yd_d = y_q;

        dx  = $signed({1'b0, xd_q}) - $signed({1'b0, xl_q});
        dy  = $signed({1'b0, yd_q}) - $signed({1'b0, yl_q});
        adx = dx[16] ? (~dx + 17'd1) : dx;
        ady = dy[16] ? (~dy + 17'd1) : dy;
        hit = ((yd_q == yl_q) && (adx <= ARM)) || ((xd_q == xl_q) && (ady <= ARM));
        mark_on_screen = (xl_q < H_LIM) && (yl_q < V_LIM);
        pix_d = (overlay_en && hit && mark_on_screen) ? MARK_COLOR : rd_data;
    end

    // Register counters, latched centroid and the output pixel.
    always_ff @(posedge clk_25_vga or negedge btn_RESET) begin
        if (!btn_RESET) begin
            addr_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            xd_q   <= '0;
            yd_q   <= '0;
            xl_q   <= '0;
            yl_q   <= '0;
            pix_q  <= '0;
        end else begin
            addr_q <= addr_d;
            x_q    <= x_d;
            y_q    <= y_d;
            xd_q   <= xd_d;
            yd_q   <= yd_d;
            xl_q   <= xl_d;
            yl_q   <= yl_d;
            pix_q  <= pix_d;
        end
    end

    assign buf_rdaddr = addr_q;
    assign pix_out    = pix_q;

endmodule

// File: rtl/fb_mode_arbiter.sv
// Frame-buffer front end: tear-free write-source selection plus VGA read/overlay.
module fb_mode_arbiter
    import fb_mode_pkg::*;
#(
    parameter int unsigned       N_SRC       = 2,
    parameter int unsigned       ADDR_W      = 17,
    parameter int unsigned       DATA_W      = 24,
    parameter int unsigned       H_RES       = 320,
    parameter int unsigned       V_RES       = 240,
    parameter int unsigned       MARK_HALF   = 4,
    parameter logic [DATA_W-1:0] MARK_COLOR  = 24'hFF0000,
    parameter int unsigned       SYNC_STAGES = 2,
    localparam int unsigned      MODE_W      = mode_w(N_SRC)
) (
    input  logic                    clk_25_vga,
    input  logic                    btn_RESET,
    input  logic [MODE_W-1:0]       mode_sel,
    input  logic [N_SRC-1:0]        src_we,
    input  logic [N_SRC*ADDR_W-1:0] src_addr,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic                    vga_vsync,
    input  logic                    active_area,
    input  logic [DATA_W-1:0]       rd_data,
    input  logic                    overlay_en,
    input  logic [15:0]             x_pos,
    input  logic [15:0]             y_pos,
    output logic                    buf_wren,
    output logic [ADDR_W-1:0]       buf_wraddr,
    output logic [DATA_W-1:0]       buf_wrdata,
    output logic [ADDR_W-1:0]       buf_rdaddr,
    output logic [DATA_W-1:0]       pix_out,
    output logic [MODE_W-1:0]       active_mode,
    output logic                    switch_pending,
    output logic [15:0]             frame_cnt
);

    localparam int unsigned     DEPTH     = fb_depth(H_RES, V_RES);
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    logic [MODE_W-1:0] sync_q [SYNC_STAGES];
    logic [MODE_W-1:0] sync_d [SYNC_STAGES];
    logic              vsync_q, vsync_d;
    logic              fs_q, fs_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    state_t            state_q, state_d;
    logic [MODE_W-1:0] active_mode_q, active_mode_d;
    logic              pend_q, pend_d;

    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;

    logic [MODE_W-1:0] msync, req_mode;
    logic              wr_allowed;

    // Synchroniser shift, frame-start edge detect, frame counter and write mux.
    always_comb begin
        sync_d[0] = mode_sel;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        msync    = sync_q[SYNC_STAGES-1];
        // Out-of-range selections read as "keep the current source".
        req_mode = (int'(msync) >= int'(N_SRC)) ? active_mode_q : msync;

        vsync_d     = vga_vsync;
        fs_d        = vsync_q & ~vga_vsync;
        frame_cnt_d = fs_q ? frame_cnt_q + 16'd1 : frame_cnt_q;

        wr_allowed = (state_q == S_RUN) || (state_q == S_PENDING);
        wraddr_d   = src_addr[int'(active_mode_q) * ADDR_W +: ADDR_W];
        wrdata_d   = src_data[int'(active_mode_q) * DATA_W +: DATA_W];
        wren_d     = src_we[active_mode_q] & wr_allowed & ({1'b0, wraddr_d} < DEPTH_CMP);
    end

    // Source-switch sequencing: a request is held until the next frame start.
    always_comb begin
        state_d       = state_q;
        active_mode_d = active_mode_q;
        case (state_q)
            S_IDLE:    if (fs_q) state_d = S_RUN;
            S_RUN:     if (req_mode != active_mode_q) state_d = S_PENDING;
            S_PENDING: begin
                if (req_mode == active_mode_q) begin
                    state_d = S_RUN;
                end else if (fs_q) begin
                    active_mode_d = req_mode;
                    state_d       = S_SWITCH;
                end
            end
            S_SWITCH:  state_d = S_RUN;
            default:   state_d = S_IDLE;
        endcase
        pend_d = (state_d == S_PENDING);
    end

    // FSM state with its registered outputs.
    always_ff @(posedge clk_25_vga or negedge btn_RESET) begin
        if (!btn_RESET) begin
            state_q       <= S_IDLE;
            active_mode_q <= '0;
            pend_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_mode_q <= active_mode_d;
            pend_q        <= pend_d;
        end
    end

    // Synchroniser, vsync edge, frame counter and registered write port.
    always_ff @(posedge clk_25_vga or negedge btn_RESET) begin
        if (!btn_RESET) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            vsync_q     <= 1'b0;
            fs_q        <= 1'b0;
            frame_cnt_q <= '0;
            wren_q      <= 1'b0;
            wraddr_q    <= '0;
            wrdata_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            vsync_q     <= vsync_d;
            fs_q        <= fs_d;
            frame_cnt_q <= frame_cnt_d;
            wren_q      <= wren_d;
            wraddr_q    <= wraddr_d;
            wrdata_q    <= wrdata_d;
        end
    end

    fb_read_overlay #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .MARK_HALF  (MARK_HALF),
        .MARK_COLOR (MARK_COLOR)
    ) u_read (
        .clk_25_vga  (clk_25_vga),
        .btn_RESET   (btn_RESET),
        .fs          (fs_q),
        .active_area (active_area),
        .rd_data     (rd_data),
        .overlay_en  (overlay_en),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .buf_rdaddr  (buf_rdaddr),
        .pix_out     (pix_out)
    );

    assign buf_wren       = wren_q;
    assign buf_wraddr     = wraddr_q;
    assign buf_wrdata     = wrdata_q;
    assign active_mode    = active_mode_q;
    assign switch_pending = pend_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_fb_mode_arbiter.sv
// Randomised scoreboard bench for fb_mode_arbiter against a pixel-index reference model.
module tb_fb_mode_arbiter;

    localparam int          N_SRC       = 3;
    localparam int          ADDR_W      = 17;
    localparam int          DATA_W      = 24;
    localparam int          H_RES       = 320;
    localparam int          V_RES       = 240;
    localparam int          MARK_HALF   = 4;
    localparam int          SYNC_STAGES = 2;
    localparam int          MODE_W      = 2;
    localparam int          DEPTH       = 76800;
    localparam logic [23:0] MARK_COLOR  = 24'hFF0000;

    logic                    clk_25_vga = 1'b0;
    logic                    btn_RESET  = 1'b0;
    logic [MODE_W-1:0]       mode_sel   = '0;
    logic [N_SRC-1:0]        src_we;
    logic [N_SRC*ADDR_W-1:0] src_addr;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic                    vga_vsync   = 1'b1;
    logic                    active_area = 1'b0;
    logic [DATA_W-1:0]       rd_data     = '0;
    logic                    overlay_en  = 1'b0;
    logic [15:0]             x_pos       = '0;
    logic [15:0]             y_pos       = '0;
    logic                    buf_wren;
    logic [ADDR_W-1:0]       buf_wraddr;
    logic [DATA_W-1:0]       buf_wrdata;
    logic [ADDR_W-1:0]       buf_rdaddr;
    logic [DATA_W-1:0]       pix_out;
    logic [MODE_W-1:0]       active_mode;
    logic                    switch_pending;
    logic [15:0]             frame_cnt;

    // Per-source stimulus, packed onto the DUT buses below.
    logic        s_we   [N_SRC];
    int          s_addr [N_SRC];
    logic [23:0] s_data [N_SRC];
    bit          use_fix = 1'b0;
    logic [23:0] rd_fix  = 24'h123456;

    int checks = 0;
    int errors = 0;

    always #20 clk_25_vga = ~clk_25_vga;

    always_comb begin
        src_we   = '0;
        src_addr = '0;
        src_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_we[i]                     = s_we[i];
            src_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(s_addr[i]);
            src_data[i*DATA_W +: DATA_W]  = s_data[i];
        end
    end

    fb_mode_arbiter #(
        .N_SRC       (N_SRC),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .H_RES       (H_RES),
        .V_RES       (V_RES),
        .MARK_HALF   (MARK_HALF),
        .MARK_COLOR  (MARK_COLOR),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_25_vga     (clk_25_vga),
        .btn_RESET      (btn_RESET),
        .mode_sel       (mode_sel),
        .src_we         (src_we),
        .src_addr       (src_addr),
        .src_data       (src_data),
        .vga_vsync      (vga_vsync),
        .active_area    (active_area),
        .rd_data        (rd_data),
        .overlay_en     (overlay_en),
        .x_pos          (x_pos),
        .y_pos          (y_pos),
        .buf_wren       (buf_wren),
        .buf_wraddr     (buf_wraddr),
        .buf_wrdata     (buf_wrdata),
        .buf_rdaddr     (buf_rdaddr),
        .pix_out        (pix_out),
        .active_mode    (active_mode),
        .switch_pending (switch_pending),
        .frame_cnt      (frame_cnt)
    );

    // ---------------- reference model + scoreboard queues ----------------
    typedef struct { int stamp; int addr; logic [23:0] data; } wr_t;
    typedef struct { int mode; int pend; int fc; int rdaddr; logic [23:0] pix; } st_t;
    wr_t wq[$];
    st_t sq[$];

    int   m_cyc = 0;
    int   m_sync[$];
    bit   m_vs_prev, m_fs, m_started, m_pend, m_blank;
    int   m_mode, m_fc, m_p, m_pp, m_xl, m_yl;
    logic [23:0] m_pix;

    task automatic model_reset();
        m_sync.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_sync.push_back(0);
        m_vs_prev = 0; m_fs = 0; m_started = 0; m_pend = 0; m_blank = 0;
        m_mode = 0; m_fc = 0; m_p = 0; m_pp = 0; m_xl = 0; m_yl = 0; m_pix = '0;
    endtask

    task automatic model_step();
        int  msync, req, x, y, dx, dy;
        bit  fs_now, hit;
        wr_t w;
        st_t s;
        m_cyc++;
        if (!btn_RESET) begin
            model_reset();
        end else begin
            fs_now = m_fs;
            msync  = m_sync[SYNC_STAGES-1];
            req    = (msync >= N_SRC) ? m_mode : msync;

            if (s_we[m_mode] && m_started && !m_blank && s_addr[m_mode] < DEPTH) begin
                w.stamp = m_cyc; w.addr = s_addr[m_mode]; w.data = s_data[m_mode];
                wq.push_back(w);
            end

            x  = m_pp % H_RES;
            y  = m_pp / H_RES;
            dx = (x > m_xl) ? x - m_xl : m_xl - x;
            dy = (y > m_yl) ? y - m_yl : m_yl - y;
            hit = (y == m_yl && dx <= MARK_HALF) || (x == m_xl && dy <= MARK_HALF);
            m_pix = (overlay_en && hit && m_xl < H_RES && m_yl < V_RES) ? MARK_COLOR : rd_data;
            m_pp = m_p;
            if (fs_now) begin
                m_p = 0; m_xl = int'(x_pos); m_yl = int'(y_pos);
            end else if (active_area) begin
                m_p = (m_p + 1) % DEPTH;
            end

            if (fs_now) m_fc = (m_fc + 1) % 65536;
            if (!m_started) begin
                if (fs_now) m_started = 1;
            end else if (m_blank) begin
                m_blank = 0;
            end else if (!m_pend) begin
                m_pend = (req != m_mode);
            end else if (req == m_mode) begin
                m_pend = 0;
            end else if (fs_now) begin
                m_mode = req; m_pend = 0; m_blank = 1;
            end

            m_fs = m_vs_prev && !vga_vsync;
            m_vs_prev = vga_vsync;
            m_sync.push_front(int'(mode_sel));
            void'(m_sync.pop_back());
        end
        s.mode = m_mode; s.pend = m_pend; s.fc = m_fc; s.rdaddr = m_p; s.pix = m_pix;
        sq.push_back(s);
    endtask

    initial forever begin
        @(posedge clk_25_vga);
        model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    // Monitor: compares presented outputs against the queued expectations.
    task automatic mon_step();
        st_t s;
        wr_t w;
        bit  exp_w;
        if (sq.size() == 0) begin
            chk("status_queue_nonempty", 64'(sq.size()), 64'd1);
            return;
        end
        s = sq.pop_front();
        if (!btn_RESET) begin
            wq.delete();
            chk("rst_buf_wren", 64'(buf_wren), 64'd0);
            chk("rst_buf_wraddr", 64'(buf_wraddr), 64'd0);
            chk("rst_buf_wrdata", 64'(buf_wrdata), 64'd0);
            chk("rst_buf_rdaddr", 64'(buf_rdaddr), 64'd0);
            chk("rst_pix_out", 64'(pix_out), 64'd0);
            chk("rst_active_mode", 64'(active_mode), 64'd0);
            chk("rst_switch_pending", 64'(switch_pending), 64'd0);
            chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
            return;
        end
        exp_w = (wq.size() > 0) && (wq[0].stamp == m_cyc);
        chk("buf_wren", 64'(buf_wren), 64'(exp_w));
        if (exp_w) begin
            w = wq.pop_front();
            if (buf_wren) begin
                chk("buf_wraddr", 64'(buf_wraddr), 64'(w.addr));
                chk("buf_wrdata", 64'(buf_wrdata), 64'(w.data));
            end
        end
        chk("active_mode", 64'(active_mode), 64'(s.mode));
        chk("switch_pending", 64'(switch_pending), 64'(s.pend));
        chk("frame_cnt", 64'(frame_cnt), 64'(s.fc));
        chk("buf_rdaddr", 64'(buf_rdaddr), 64'(s.rdaddr));
        chk("pix_out", 64'(pix_out), 64'(s.pix));
    endtask

    initial forever begin
        @(negedge clk_25_vga);
        mon_step();
    end

    // ---------------- stimulus ----------------
    function automatic int rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return DEPTH + $urandom_range(0, 5);
        if (r == 1) return DEPTH - 1;
        if (r == 2) return (1 << ADDR_W) - 1;
        return $urandom_range(0, DEPTH - 1);
    endfunction

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk_25_vga);
            #5;
        end
    endtask

    task automatic run(input int n, input bit rnd_wr, input int act_pct);
        repeat (n) begin
            @(posedge clk_25_vga);
            #5;
            for (int i = 0; i < N_SRC; i++) begin
                s_we[i]   = rnd_wr ? 1'($urandom_range(0, 1)) : 1'b0;
                s_addr[i] = rand_addr();
                s_data[i] = 24'($urandom());
            end
            rd_data     = use_fix ? rd_fix : 24'($urandom());
            active_area = ($urandom_range(0, 99) < act_pct);
        end
    endtask

    task automatic frame_start();
        @(posedge clk_25_vga);
        #5;
        vga_vsync = 1'b0;
        hold(2);
        vga_vsync = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N_SRC; i++) begin
            s_we[i] = 1'b0; s_addr[i] = 0; s_data[i] = '0;
        end
        hold(3);
        btn_RESET = 1'b1;

        // Writes before the first frame start must be suppressed.
        s_we[0] = 1'b1; s_addr[0] = 5; s_data[0] = 24'hABCDEF;
        hold(6);
        frame_start();
        hold(4);
        run(200, 1'b1, 80);

        // Switch 0 -> 1 mid-frame, committed at the next frame start.
        mode_sel = 2'd1;
        run(30, 1'b1, 80);
        frame_start();
        run(60, 1'b1, 80);

        // Request that is withdrawn within the frame.
        mode_sel = 2'd0;
        run(8, 1'b1, 80);
        mode_sel = 2'd1;
        run(20, 1'b1, 80);
        frame_start();
        run(20, 1'b1, 80);

        // Out-of-range selection is ignored; then a real switch to source 2.
        mode_sel = 2'd3;
        run(20, 1'b1, 80);
        mode_sel = 2'd2;
        run(10, 1'b1, 80);
        frame_start();
        run(30, 1'b1, 80);
        mode_sel = 2'd0;
        run(5, 1'b1, 80);
        frame_start();
        run(10, 1'b1, 80);

        // Write address boundary on the active source.
        s_we[0] = 1'b1; s_addr[0] = DEPTH;
        hold(3);
        s_addr[0] = DEPTH - 1;
        hold(2);

        // Full frame: crosshair at (10,20) over constant data, then address wrap.
        overlay_en = 1'b1; x_pos = 16'd10; y_pos = 16'd20; use_fix = 1'b1;
        frame_start();
        run(DEPTH + 40, 1'b1, 100);

        // Right and top edge clipping.
        x_pos = 16'd318; y_pos = 16'd1;
        frame_start();
        run(2000, 1'b1, 100);

        // Off-screen centroid draws nothing.
        x_pos = 16'd400; y_pos = 16'd3;
        frame_start();
        run(700, 1'b1, 100);
        use_fix = 1'b0;

        // Random frames with random switching and overlay settings.
        repeat (4) begin
            mode_sel   = 2'($urandom_range(0, 3));
            overlay_en = 1'($urandom_range(0, 1));
            x_pos      = 16'($urandom_range(0, 330));
            y_pos      = 16'($urandom_range(0, 3));
            run($urandom_range(50, 300), 1'b1, 70);
            frame_start();
            run($urandom_range(200, 500), 1'b1, 90);
        end

        // Reset mid-frame: immediate idle, no writes until the next frame start.
        run(10, 1'b1, 80);
        btn_RESET = 1'b0;
        hold(2);
        btn_RESET = 1'b1;
        run(10, 1'b1, 80);
        frame_start();
        run(30, 1'b1, 80);

        hold(3);
        chk("write_queue_drained", 64'(wq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
